// File: rtl/cla_op_sequencer.sv
// ---------------------------------------------------------------------------
// cla_op_sequencer
//   Multi-cycle sequencer that time-shares one external 8-bit carry-lookahead
//   adder. It computes 16-bit ADD/SUB as two byte passes with chained carry,
//   and 8x8 unsigned MUL as MUL_STEPS shift-add passes.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_ready is 1 only in IDLE
//   req_op               00 ADD16, 01 SUB16, 10 MUL8, 11 reserved
//   req_a, req_b         16-bit operands (MUL uses [7:0])
//   rsp_valid/rsp_ready  response handshake
//   rsp_result           sum / difference / product
//   rsp_carry            ADD: carry-out; SUB: 1 = no borrow; MUL: 0
//   rsp_ovf              ADD/SUB: signed overflow; MUL: product > 255;
//                        reserved op: 1
//   add_a/add_b/add_ci   operands driven to the external adder
//   add_s/add_co         external adder result (combinational)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid (and its payload) until that edge; the
// consumer may raise or lower ready freely. Here rsp_valid/result/flags are
// registered and stay frozen until the rsp handshake edge, and a request is
// only taken while IDLE, so request and response never overlap.
// ---------------------------------------------------------------------------
module cla_op_sequencer #(
  parameter int W         = 8,
  parameter int MUL_STEPS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_carry,
  output logic           rsp_ovf,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_ci,
  input  logic [W-1:0]   add_s,
  input  logic           add_co
);

  localparam int SW = $clog2(MUL_STEPS);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state;
  logic [2*W-1:0] a_q;      // operand A as captured at accept
  logic [2*W-1:0] b_q;      // operand B, already inverted for SUB
  logic           cin_q;    // carry into the low byte (1 for SUB)
  logic           c_reg;    // carry from low byte into high byte
  logic [W-1:0]   res_lo;   // low byte of ADD/SUB result
  logic [W-1:0]   mul_hi;   // running partial product, upper half
  logic [W-1:0]   mul_lo;   // multiplier bits shifting out / product lower half
  logic [SW-1:0]  step;

  // One shift-add pass: {carry, sum, lo} shifted right by one. The top byte
  // becomes the new partial product and the sum's LSB enters lo.
  logic [2*W:0]   mul_shift;
  logic           hi_ovf;

  assign mul_shift = {add_co, add_s, mul_lo} >> 1;

  // Signed overflow: both addends share a sign and the sum sign differs.
  assign hi_ovf = (a_q[2*W-1] == b_q[2*W-1]) && (add_s[W-1] != a_q[2*W-1]);

  assign req_ready = (state == S_IDLE);

  // Adder operands are a pure function of registered state, so they are
  // stable for the whole cycle and zero whenever the adder is not in use.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state)
      S_LO: begin
        add_a  = a_q[W-1:0];
        add_b  = b_q[W-1:0];
        add_ci = cin_q;
      end
      S_HI: begin
        add_a  = a_q[2*W-1:W];
        add_b  = b_q[2*W-1:W];
        add_ci = c_reg;
      end
      S_MUL: begin
        add_a  = mul_hi;
        add_b  = mul_lo[0] ? a_q[W-1:0] : '0;
        add_ci = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      c_reg      <= 1'b0;
      res_lo     <= '0;
      mul_hi     <= '0;
      mul_lo     <= '0;
      step       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q    <= req_a;
            // Subtraction is A + ~B + 1 through the same adder.
            b_q    <= (req_op == OP_SUB) ? ~req_b : req_b;
            cin_q  <= (req_op == OP_SUB);
            mul_hi <= '0;
            mul_lo <= req_b[W-1:0];
            step   <= '0;
            case (req_op)
              OP_ADD, OP_SUB: state <= S_LO;
              OP_MUL:         state <= S_MUL;
              default: begin
                // Reserved op: answer immediately with the error flag.
                state      <= S_DONE;
                rsp_valid  <= 1'b1;
                rsp_result <= '0;
                rsp_carry  <= 1'b0;
                rsp_ovf    <= 1'b1;
              end
            endcase
          end
        end

        S_LO: begin
          res_lo <= add_s;
          c_reg  <= add_co;
          state  <= S_HI;
        end

        S_HI: begin
          rsp_result <= {add_s, res_lo};
          rsp_carry  <= add_co;
          rsp_ovf    <= hi_ovf;
          rsp_valid  <= 1'b1;
          state      <= S_DONE;
        end

        S_MUL: begin
          mul_hi <= mul_shift[2*W-1:W];
          mul_lo <= mul_shift[W-1:0];
          step   <= step + 1'b1;
          if (step == SW'(MUL_STEPS - 1)) begin
            rsp_result <= mul_shift[2*W-1:0];
            rsp_carry  <= 1'b0;
            rsp_ovf    <= |mul_shift[2*W-1:W];
            rsp_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_op_sequencer.sv
module tb_cla_op_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_ci;
  logic [7:0]  add_s;
  logic        add_co;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared 8-bit CLA: a plain combinational adder.
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};

  cla_op_sequencer #(.W(8), .MUL_STEPS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_ci     (add_ci),
    .add_s      (add_s),
    .add_co     (add_co)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {ovf, carry, result}
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [17:0] ref_model(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        o;
    int unsigned p;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'd1: begin
        r = a - b;
        c = (a >= b);
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'd2: begin
        p = int'(a[7:0]) * int'(b[7:0]);
        r = p[15:0];
        c = 1'b0;
        o = (p > 255);
      end
      default: begin
        r = 16'd0;
        c = 1'b0;
        o = 1'b1;
      end
    endcase
    return {o, c, r};
  endfunction

  function automatic int ref_latency(input logic [1:0] op);
    case (op)
      2'd0, 2'd1: return 3;
      2'd2:       return 9;
      default:    return 1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request, wait for the response, hold backpressure for bp
  // cycles, then complete the handshake. Expected values come from exp_q.
  task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int bp);
    logic [17:0] e;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        eci;
    logic [8:0]  esum;
    int          lat;
    e = exp_q.pop_front();
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs: operands must have been captured at accept.
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    lat = 1;
    if (op != 2'd3) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      case (op)
        2'd0: begin ea = a[7:0]; eb = b[7:0];  eci = 1'b0; end
        2'd1: begin ea = a[7:0]; eb = ~b[7:0]; eci = 1'b1; end
        default: begin ea = 8'd0; eb = b[0] ? a[7:0] : 8'd0; eci = 1'b0; end
      endcase
      esum = {1'b0, ea} + {1'b0, eb} + {8'd0, eci};
      check("first_pass_add_in", {15'd0, add_ci, add_b, add_a}, {15'd0, eci, eb, ea});
      check("first_pass_add_co", 32'(add_co), 32'(esum[8]));
    end
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(ref_latency(op)));
    if (!rsp_valid) begin
      apply_reset();
    end else begin
      for (int i = 0; i <= bp; i++) begin
        check("rsp_result", 32'(rsp_result), 32'(e[15:0]));
        check("rsp_flags", {30'd0, rsp_ovf, rsp_carry}, {30'd0, e[17], e[16]});
        check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
        check("req_ready_done", 32'(req_ready), 32'd0);
        check("adder_idle_done", {15'd0, add_ci, add_b, add_a}, 32'd0);
        if (i < bp) begin
          // Stray request while a response is pending: must be ignored.
          req_valid = 1'b1;
          req_op    = 2'($urandom_range(0, 2));
          @(negedge clk);
        end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_clear", 32'(rsp_valid), 32'd0);
      check("rsp_result_clear", {14'd0, rsp_ovf, rsp_carry, rsp_result}, 32'd0);
      check("req_ready_after", 32'(req_ready), 32'd1);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        c;
    logic        o;
    int          bp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int stray;
    vecs[0] = '{2'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 0};
    vecs[1] = '{2'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 0};
    vecs[2] = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1};
    vecs[3] = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 0};
    vecs[4] = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 5};
    vecs[5] = '{2'd2, 16'h12FF, 16'h34FF, 16'hFE01, 1'b0, 1'b1, 0};
    vecs[6] = '{2'd2, 16'h000D, 16'h000B, 16'h008F, 1'b0, 1'b0, 2};
    vecs[7] = '{2'd2, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b0, 0};
    vecs[8] = '{2'd3, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 5};
    vecs[9] = '{2'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 0};

    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("reset_rsp", {14'd0, rsp_valid, rsp_carry, rsp_result}, 32'd0);
    check("reset_ovf", 32'(rsp_ovf), 32'd0);
    check("reset_adder", {15'd0, add_ci, add_b, add_a}, 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].o, vecs[i].c, vecs[i].r});
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].bp);
    end

    // Reset in the middle of a MUL (step 4) aborts without a response.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_a     = 16'h00FF;
    req_b     = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_adder", {15'd0, add_ci, add_b, add_a}, 32'd0);
    check("midreset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    check("midreset_no_rsp", 32'(stray), 32'd0);
    exp_q.push_back(ref_model(2'd0, 16'd1, 16'd2));
    run_txn(2'd0, 16'd1, 16'd2, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i % 8 == 0) a = 16'hFFFF;
      if (i % 8 == 4) b = 16'h8000;
      exp_q.push_back(ref_model(op, a, b));
      run_txn(op, a, b, $urandom_range(0, 3));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
